// File: rtl/range_gate_sequencer.sv
// range_gate_sequencer
//   Per-shot acquisition sequencer for the lidar datapath. Passes a sample pair
//   through one register stage and, once armed by a trigger edge, strobes the
//   downstream FFT/accumulator over SHOTS x GATES x GLEN clocks per frame.
//   Configuration is latched when a frame is armed and ignored while busy.
// Ports
//   clk_i, rst_i          clock, synchronous active-high reset
//   enable_i              arms frames; low aborts a frame in progress
//   trigger_i             laser trigger, rising edge used
//   cfg_delay_i           clocks from trigger edge to first gate sample (0 legal)
//   cfg_glen_i            clocks per range gate
//   cfg_gates_i           range gates per shot
//   cfg_shots_i           shots per frame
//   x0_i, x0z_i           sample pair in
//   y0_o, y0z_o           sample pair delayed one clock (free running)
//   valid_o               y0/y0z belong to a gate
//   gate_start_o/_end_o   first / last valid cycle of a gate
//   gate_idx_o            current gate index (0-based)
//   shot_idx_o            current shot index (0-based)
//   acc_first_o           valid during shot 0 (accumulator overwrites)
//   busy_o                sequencer not idle
//   frame_done_o          pulse after the final gate of the final shot
//   trig_miss_o           pulse: trigger edge ignored during DELAY/GATE
//   cfg_err_o             pulse: arm refused, a length/count field is zero
module range_gate_sequencer #(
  parameter int DW = 16,
  parameter int CW = 16,
  parameter int GW = 8
) (
  input  logic                 clk_i,
  input  logic                 rst_i,
  input  logic                 enable_i,
  input  logic                 trigger_i,
  input  logic [CW-1:0]        cfg_delay_i,
  input  logic [CW-1:0]        cfg_glen_i,
  input  logic [GW-1:0]        cfg_gates_i,
  input  logic [CW-1:0]        cfg_shots_i,
  input  logic signed [DW-1:0] x0_i,
  input  logic signed [DW-1:0] x0z_i,
  output logic signed [DW-1:0] y0_o,
  output logic signed [DW-1:0] y0z_o,
  output logic                 valid_o,
  output logic                 gate_start_o,
  output logic                 gate_end_o,
  output logic [GW-1:0]        gate_idx_o,
  output logic [CW-1:0]        shot_idx_o,
  output logic                 acc_first_o,
  output logic                 busy_o,
  output logic                 frame_done_o,
  output logic                 trig_miss_o,
  output logic                 cfg_err_o
);

  typedef enum logic [1:0] {S_IDLE, S_DELAY, S_GATE, S_WAIT_TRIG} state_e;

  localparam logic [CW-1:0] ONE_C = CW'(1);
  localparam logic [GW-1:0] ONE_G = GW'(1);

  state_e         state_q, state_d;
  logic           trig_q;
  logic           trg;
  logic [CW-1:0]  delay_q, delay_d;
  logic [CW-1:0]  glen_q, glen_d;
  logic [GW-1:0]  gates_q, gates_d;
  logic [CW-1:0]  shots_q, shots_d;
  logic [CW-1:0]  cnt_q, cnt_d;     // shared: delay count in DELAY, sample count in GATE
  logic [GW-1:0]  gate_q, gate_d;
  logic [CW-1:0]  shot_q, shot_d;
  logic           done_q, done_d;
  logic           miss_q, miss_d;
  logic           err_q, err_d;
  logic           last_sample, last_gate, last_shot;
  logic signed [DW-1:0] y0_q, y0z_q;

  assign trg         = trigger_i & ~trig_q;
  assign last_sample = (cnt_q == glen_q - ONE_C);
  assign last_gate   = (gate_q == gates_q - ONE_G);
  assign last_shot   = (shot_q == shots_q - ONE_C);

  always_comb begin
    state_d = state_q;
    delay_d = delay_q;
    glen_d  = glen_q;
    gates_d = gates_q;
    shots_d = shots_q;
    cnt_d   = cnt_q;
    gate_d  = gate_q;
    shot_d  = shot_q;
    done_d  = 1'b0;
    miss_d  = 1'b0;
    err_d   = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (trg && enable_i) begin
          delay_d = cfg_delay_i;
          glen_d  = cfg_glen_i;
          gates_d = cfg_gates_i;
          shots_d = cfg_shots_i;
          // A zero delay is legal (gate starts immediately); zero lengths/counts are not.
          if (cfg_glen_i == '0 || cfg_gates_i == '0 || cfg_shots_i == '0) begin
            err_d = 1'b1;
          end else begin
            shot_d  = '0;
            gate_d  = '0;
            cnt_d   = '0;
            state_d = (cfg_delay_i != '0) ? S_DELAY : S_GATE;
          end
        end
      end
      S_DELAY: begin
        miss_d = trg;
        if (cnt_q == delay_q - ONE_C) begin
          cnt_d   = '0;
          state_d = S_GATE;
        end else begin
          cnt_d = cnt_q + ONE_C;
        end
      end
      S_GATE: begin
        miss_d = trg;
        if (last_sample) begin
          cnt_d = '0;
          if (last_gate) begin
            gate_d = '0;
            if (last_shot) begin
              shot_d  = '0;
              done_d  = 1'b1;
              state_d = S_IDLE;
            end else begin
              shot_d  = shot_q + ONE_C;
              state_d = S_WAIT_TRIG;
            end
          end else begin
            gate_d = gate_q + ONE_G;
          end
        end else begin
          cnt_d = cnt_q + ONE_C;
        end
      end
      S_WAIT_TRIG: begin
        if (trg) begin
          cnt_d   = '0;
          gate_d  = '0;
          state_d = (delay_q != '0) ? S_DELAY : S_GATE;
        end
      end
      default: state_d = S_IDLE;
    endcase
    // Dropping enable abandons the frame from any active state without completion.
    if (state_q != S_IDLE && !enable_i) begin
      state_d = S_IDLE;
      cnt_d   = '0;
      gate_d  = '0;
      shot_d  = '0;
      done_d  = 1'b0;
      miss_d  = 1'b0;
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q <= S_IDLE;
      trig_q  <= 1'b0;
      delay_q <= '0;
      glen_q  <= '0;
      gates_q <= '0;
      shots_q <= '0;
      cnt_q   <= '0;
      gate_q  <= '0;
      shot_q  <= '0;
      done_q  <= 1'b0;
      miss_q  <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      trig_q  <= trigger_i;
      delay_q <= delay_d;
      glen_q  <= glen_d;
      gates_q <= gates_d;
      shots_q <= shots_d;
      cnt_q   <= cnt_d;
      gate_q  <= gate_d;
      shot_q  <= shot_d;
      done_q  <= done_d;
      miss_q  <= miss_d;
      err_q   <= err_d;
    end
  end

  // Sample pair delay stage: runs continuously, cleared only by reset.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      y0_q  <= '0;
      y0z_q <= '0;
    end else begin
      y0_q  <= x0_i;
      y0z_q <= x0z_i;
    end
  end

  assign y0_o         = y0_q;
  assign y0z_o        = y0z_q;
  assign valid_o      = (state_q == S_GATE);
  assign gate_start_o = valid_o && (cnt_q == '0);
  assign gate_end_o   = valid_o && last_sample;
  assign gate_idx_o   = gate_q;
  assign shot_idx_o   = shot_q;
  assign acc_first_o  = valid_o && (shot_q == '0);
  assign busy_o       = (state_q != S_IDLE);
  assign frame_done_o = done_q;
  assign trig_miss_o  = miss_q;
  assign cfg_err_o    = err_q;

endmodule

// File: tb/tb_range_gate_sequencer.sv
module tb_range_gate_sequencer;

  logic clk = 1'b0;
  logic rst, en, trig;
  logic [15:0] cd, cgl, csh;
  logic [7:0]  cga;
  logic signed [15:0] x0, x0z;
  logic signed [15:0] y0, y0z;
  logic valid, gs, ge, acc, busy, fd, miss, err;
  logic [7:0]  gidx;
  logic [15:0] sidx;

  int cyc = 0;
  int total = 0;
  int bad = 0;

  always #5 clk = ~clk;

  range_gate_sequencer #(.DW(16), .CW(16), .GW(8)) dut (
    .clk_i(clk), .rst_i(rst), .enable_i(en), .trigger_i(trig),
    .cfg_delay_i(cd), .cfg_glen_i(cgl), .cfg_gates_i(cga), .cfg_shots_i(csh),
    .x0_i(x0), .x0z_i(x0z), .y0_o(y0), .y0z_o(y0z),
    .valid_o(valid), .gate_start_o(gs), .gate_end_o(ge),
    .gate_idx_o(gidx), .shot_idx_o(sidx), .acc_first_o(acc),
    .busy_o(busy), .frame_done_o(fd), .trig_miss_o(miss), .cfg_err_o(err)
  );

  // Advance one clock; afterwards cyc is the index of the edge just taken and
  // x0 holds the ramp value that the next edge (cyc+1) will sample.
  task automatic step();
    @(posedge clk);
    cyc++;
    #1;
    x0  = 16'(cyc + 1);
    x0z = ~16'(cyc + 1);
  endtask

  task automatic set_cfg(input int d, input int gl, input int ga, input int sh);
    cd  = 16'(d);
    cgl = 16'(gl);
    cga = 8'(ga);
    csh = 16'(sh);
  endtask

  // Trigger edge sampled on the next clock; returns with that edge (T) taken.
  task automatic fire();
    trig = 1'b1;
    step();
    trig = 1'b0;
  endtask

  task automatic test_reset();
    logic [63:0] allv;
    logic [15:0] e;
    rst = 1'b1;
    en  = 1'b1;
    trig = 1'b0;
    set_cfg(3, 4, 2, 1);
    step(); step(); step();
    allv = {y0, y0z, valid, gs, ge, gidx, sidx, acc, busy, fd, miss, err};
    total++;
    if (allv !== 64'd0) begin
      bad++;
      $display("FAIL reset_outputs got=%h exp=%h", allv, 64'd0);
    end
    rst = 1'b0;
    step();
    e = 16'(cyc);
    total++;
    if (y0 !== e || y0z !== ~e) begin
      bad++;
      $display("FAIL passthrough got=%h/%h exp=%h/%h", y0, y0z, e, ~e);
    end
  endtask

  task automatic test_single_frame();
    int t, nv;
    logic [4:0] g, e;
    logic [15:0] ey;
    set_cfg(3, 4, 2, 1);
    fire();
    t = cyc;
    // Config changes while busy must not disturb the frame.
    set_cfg(0, 1, 7, 5);
    nv = 0;
    for (int k = 0; k < 14; k++) begin
      g = {valid, gs, ge, fd, busy};
      e = {k >= 3 && k <= 10, k == 3 || k == 7, k == 6 || k == 10, k == 11, k < 11};
      total++;
      if (g !== e) begin
        bad++;
        $display("FAIL frame1_strobes k=%0d got=%b exp=%b", k, g, e);
      end
      total++;
      if (gidx !== ((k >= 7 && k <= 10) ? 8'd1 : 8'd0)) begin
        bad++;
        $display("FAIL frame1_gate_idx k=%0d got=%0d", k, gidx);
      end
      if (valid === 1'b1) begin
        nv++;
        ey = 16'(t + k);
        total++;
        if (y0 !== ey) begin
          bad++;
          $display("FAIL frame1_data k=%0d got=%h exp=%h", k, y0, ey);
        end
      end
      step();
    end
    total++;
    if (nv != 8) begin
      bad++;
      $display("FAIL frame1_word_count got=%0d exp=8", nv);
    end
    set_cfg(3, 4, 2, 1);
  endtask

  task automatic test_multi_shot();
    int nv, nacc, nfd, nmiss;
    set_cfg(3, 4, 2, 3);
    nfd = 0;
    nmiss = 0;
    for (int s = 0; s < 3; s++) begin
      fire();
      nv = 0;
      nacc = 0;
      for (int k = 0; k < 200; k++) begin
        if (valid === 1'b1) begin
          nv++;
          if (acc === 1'b1) nacc++;
          total++;
          if (sidx !== 16'(s)) begin
            bad++;
            $display("FAIL shot_idx s=%0d k=%0d got=%0d exp=%0d", s, k, sidx, s);
          end
        end
        if (fd === 1'b1) nfd++;
        if (miss === 1'b1) nmiss++;
        if (k == 11) begin
          total++;
          if (busy !== 1'(s < 2)) begin
            bad++;
            $display("FAIL shot_busy s=%0d got=%b exp=%b", s, busy, 1'(s < 2));
          end
        end
        step();
      end
      total++;
      if (nv != 8) begin
        bad++;
        $display("FAIL shot_words s=%0d got=%0d exp=8", s, nv);
      end
      total++;
      if (nacc != ((s == 0) ? 8 : 0)) begin
        bad++;
        $display("FAIL acc_first s=%0d got=%0d exp=%0d", s, nacc, (s == 0) ? 8 : 0);
      end
    end
    total++;
    if (nfd != 1 || nmiss != 0) begin
      bad++;
      $display("FAIL multi_frame_done got=%0d/%0d exp=1/0", nfd, nmiss);
    end
  endtask

  task automatic test_trig_miss();
    logic [5:0] g, e;
    set_cfg(3, 4, 2, 1);
    fire();
    for (int k = 0; k < 14; k++) begin
      g = {valid, gs, ge, fd, busy, miss};
      e = {k >= 3 && k <= 10, k == 3 || k == 7, k == 6 || k == 10, k == 11, k < 11, k == 5};
      total++;
      if (g !== e) begin
        bad++;
        $display("FAIL trig_miss k=%0d got=%b exp=%b", k, g, e);
      end
      if (k == 4) trig = 1'b1;
      if (k == 5) trig = 1'b0;
      step();
    end
    trig = 1'b0;
    step();
  endtask

  task automatic test_cfg_err();
    int bl[3][3] = '{'{0, 2, 1}, '{4, 0, 1}, '{4, 2, 0}};
    logic [1:0] g;
    for (int i = 0; i < 3; i++) begin
      set_cfg(3, bl[i][0], bl[i][1], bl[i][2]);
      fire();
      g = {err, busy};
      total++;
      if (g !== 2'b10) begin
        bad++;
        $display("FAIL cfg_err%0d got=%b exp=10", i, g);
      end
      step();
      g = {err, busy};
      total++;
      if (g !== 2'b00) begin
        bad++;
        $display("FAIL cfg_err%0d_after got=%b exp=00", i, g);
      end
    end
  endtask

  task automatic test_back_to_back();
    logic [5:0] g;
    logic [5:0] e[5] = '{6'b111011, 6'b000100, 6'b111011, 6'b000100, 6'b000000};
    set_cfg(0, 1, 1, 1);
    fire();
    for (int k = 0; k < 5; k++) begin
      g = {valid, gs, ge, fd, busy, acc};
      total++;
      if (g !== e[k]) begin
        bad++;
        $display("FAIL min_gate k=%0d got=%b exp=%b", k, g, e[k]);
      end
      // Re-trigger on the frame_done cycle: sampled while IDLE, so it arms again.
      if (k == 1) trig = 1'b1;
      step();
      trig = 1'b0;
    end
  endtask

  task automatic test_abort(input bit use_rst);
    logic [2:0] g;
    logic [3:0] g4;
    int nfd, nv;
    set_cfg(3, 4, 2, 2);
    fire();
    repeat (14) step();
    fire();
    repeat (4) step();
    total++;
    if (valid !== 1'b1 || sidx !== 16'd1) begin
      bad++;
      $display("FAIL abort%0d_pre got=%b/%0d exp=1/1", use_rst, valid, sidx);
    end
    if (use_rst) rst = 1'b1;
    else en = 1'b0;
    step();
    g = {valid, busy, fd};
    total++;
    if (g !== 3'b000 || (use_rst && y0 !== 16'sd0)) begin
      bad++;
      $display("FAIL abort%0d_state got=%b y0=%h exp=000", use_rst, g, y0);
    end
    rst = 1'b0;
    nfd = 0;
    nv = 0;
    repeat (20) begin
      step();
      if (fd === 1'b1) nfd++;
      if (valid === 1'b1) nv++;
    end
    en = 1'b1;
    total++;
    if (nfd != 0 || nv != 0) begin
      bad++;
      $display("FAIL abort%0d_quiet got=%0d/%0d exp=0/0", use_rst, nfd, nv);
    end
    fire();
    repeat (3) step();
    g4 = {valid, gs, acc, busy};
    total++;
    if (g4 !== 4'b1111 || sidx !== 16'd0) begin
      bad++;
      $display("FAIL abort%0d_restart got=%b/%0d exp=1111/0", use_rst, g4, sidx);
    end
    en = 1'b0;
    step();
    en = 1'b1;
    step();
  endtask

  initial begin
    rst  = 1'b1;
    en   = 1'b0;
    trig = 1'b0;
    x0   = 16'sd1;
    x0z  = ~16'sd1;
    set_cfg(0, 0, 0, 0);
    test_reset();
    test_single_frame();
    test_multi_shot();
    test_trig_miss();
    test_cfg_err();
    test_back_to_back();
    test_abort(1'b0);
    test_abort(1'b1);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
